// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU.
// Produces one quotient bit per cycle on operand magnitudes, then applies sign correction.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_start,
    input  logic                  div_signed,
    input  logic                  div_cancel,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    output logic                  div_busy,
    output logic                  div_done,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [4:0]     cnt;
    logic           sx;
    logic           sy;
    logic           dz;
    logic [W-1:0]   x_orig;
    logic [W-1:0]   y_mag;
    logic [W-1:0]   q_work;
    logic [W-1:0]   r_work;
    logic [W:0]     r_shift;
    logic [W:0]     trial;

    function automatic logic [W-1:0] cond_neg(input logic neg, input logic [W-1:0] v);
        return neg ? ({W{1'b0}} - v) : v;
    endfunction

    // The 33-bit partial remainder only exists as r_shift; after each step it is below |y|, so 32 bits are stored.
    always_comb begin
        r_shift = {r_work, q_work[W-1]};
        trial   = r_shift - {1'b0, y_mag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (div_start && !div_cancel) state_next = CALC;
            CALC: begin
                if (div_cancel) begin
                    state_next = IDLE;
                end else if (cnt == 5'd31) begin
                    state_next = SIGN;
                end
            end
            SIGN:    state_next = div_cancel ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        div_busy = (state != IDLE);
        div_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 5'd0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            dz        <= 1'b0;
            x_orig    <= '0;
            y_mag     <= '0;
            q_work    <= '0;
            r_work    <= '0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start && !div_cancel) begin
                        sx     <= div_signed & x[W-1];
                        sy     <= div_signed & y[W-1];
                        q_work <= cond_neg(div_signed & x[W-1], x);
                        y_mag  <= cond_neg(div_signed & y[W-1], y);
                        r_work <= '0;
                        cnt    <= 5'd0;
                        dz     <= (y == '0);
                        x_orig <= x;
                    end
                end
                CALC: begin
                    if (!div_cancel) begin
                        cnt    <= cnt + 5'd1;
                        q_work <= {q_work[W-2:0], ~trial[W]};
                        r_work <= trial[W] ? r_shift[W-1:0] : trial[W-1:0];
                    end
                end
                SIGN: begin
                    // A flush here must leave the previously committed results intact.
                    if (!div_cancel) begin
                        div_zero <= dz;
                        if (dz) begin
                            quotient  <= '1;
                            remainder <= x_orig;
                        end else begin
                            quotient  <= cond_neg(sx ^ sy, q_work);
                            remainder <= cond_neg(sx, r_work);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a negedge monitor checks each done pulse.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic        div_cancel;
    logic [31:0] x;
    logic [31:0] y;
    logic        div_busy;
    logic        div_done;
    logic        div_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_cancel (div_cancel),
        .x          (x),
        .y          (y),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_zero   (div_zero),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns one cycle later. Done is expected 34 cycles after the start cycle.
    task automatic start_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                             input bit push, input logic [31:0] eq, input logic [31:0] er,
                             input logic ez);
        exp_t e;
        div_start  = 1'b1;
        div_signed = s;
        x          = a;
        y          = b;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.z   = ez;
            e.cyc = cyc + 34;
            sb.push_back(e);
        end
        step(1);
        div_start  = 1'b0;
        div_signed = ~s;
        x          = $urandom;
        y          = $urandom;
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic ez);
        start_div(s, a, b, 1'b1, eq, er, ez);
        step(34);
    endtask

    always @(negedge clk) begin
        if (!rst && div_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_zero", {31'd0, div_zero}, {31'd0, e.z});
            end
        end
    end

    initial begin
        int t;
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_cancel = 1'b0;
        x          = '0;
        y          = '0;
        step(2);
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        check("rst_done", {31'd0, div_done}, 32'd0);
        check("rst_zero", {31'd0, div_zero}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        rst = 1'b0;
        step(1);

        // Basic unsigned with busy window
        t = cyc;
        check("busy_before", {31'd0, div_busy}, 32'd0);
        start_div(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        check("busy_first", {31'd0, div_busy}, 32'd1);
        step(t + 34 - cyc);
        check("busy_done_cycle", {31'd0, div_busy}, 32'd1);
        step(1);
        check("busy_after", {31'd0, div_busy}, 32'd0);

        // Sign handling and boundary vectors, issued back to back
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 32'd1,         1'b0);
        run_div(1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0);
        run_div(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD,  32'd2,         32'hFFFF_FFFE, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b0);
        run_div(1'b1, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        run_div(1'b0, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        run_div(1'b1, 32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1);

        // Ignored start while busy, cancel mid-CALC, then restart
        t = cyc;
        start_div(1'b0, 32'd20, 32'd3, 1'b0, '0, '0, 1'b0);
        step(t + 5 - cyc);
        div_start = 1'b1;
        x = 32'd100;
        y = 32'd7;
        step(1);
        div_start = 1'b0;
        step(t + 10 - cyc);
        div_cancel = 1'b1;
        step(1);
        div_cancel = 1'b0;
        check("cancel_busy", {31'd0, div_busy}, 32'd0);
        check("cancel_quotient", quotient, 32'hFFFF_FFFF);
        check("cancel_remainder", remainder, 32'hFFFF_FFF0);
        check("cancel_zero", {31'd0, div_zero}, 32'd1);
        step(t + 12 - cyc);
        start_div(1'b0, 32'd20, 32'd3, 1'b1, 32'd6, 32'd2, 1'b0);
        step(t + 47 - cyc);

        // Cancel during SIGN must not commit results
        t = cyc;
        start_div(1'b0, 32'd50, 32'd5, 1'b0, '0, '0, 1'b0);
        step(t + 33 - cyc);
        div_cancel = 1'b1;
        step(1);
        div_cancel = 1'b0;
        check("sign_cancel_busy", {31'd0, div_busy}, 32'd0);
        check("sign_cancel_quotient", quotient, 32'd6);
        check("sign_cancel_remainder", remainder, 32'd2);

        // Cancel during DONE: pulse still occurs
        t = cyc;
        start_div(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0);
        step(t + 34 - cyc);
        div_cancel = 1'b1;
        step(1);
        div_cancel = 1'b0;
        check("done_cancel_busy", {31'd0, div_busy}, 32'd0);

        // Start together with cancel in IDLE is dropped
        div_start  = 1'b1;
        div_cancel = 1'b1;
        x = 32'd9;
        y = 32'd4;
        step(1);
        div_start  = 1'b0;
        div_cancel = 1'b0;
        check("start_cancel_busy", {31'd0, div_busy}, 32'd0);
        step(2);
        check("start_cancel_busy_later", {31'd0, div_busy}, 32'd0);

        // Asynchronous reset mid-CALC
        t = cyc;
        start_div(1'b1, 32'hFFFF_FF9C, 32'd3, 1'b0, '0, '0, 1'b0);
        step(t + 15 - cyc);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, div_busy}, 32'd0);
        check("arst_done", {31'd0, div_done}, 32'd0);
        check("arst_zero", {31'd0, div_zero}, 32'd0);
        check("arst_quotient", quotient, 32'd0);
        check("arst_remainder", remainder, 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        run_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);
        step(2);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
